// File: rtl/mem_cmd_if.sv
// ---------------------------------------------------------------------------
// mem_cmd_if
// Handshake/data bundle between the I/O control front end and the memory
// command controller.
//
//   master modport : upstream side (drives command, address, write data and
//                    the request strobe; receives done/read data/errors)
//   slave modport  : mem_cmd_ctrl side
//
//   memCmd        2   command: 00 NOP, 01 WRITE, 10 READ, 11 CLEAR
//   memAddrOut    64  word address
//   ioDataOut     32  write data
//   ioCmdDoneOut  1   request strobe, rising edge issues a request
//   memCmdDoneIn  1   1 = idle/complete, 0 = busy
//   memDataIn     32  read result
//   addrErr       1   one-cycle pulse on out-of-range address
//   parErr        1   one-cycle parity error pulse (PARITY_CHECK_EN only)
//
// Optional feature macro: PARITY_CHECK_EN adds the parErr signal.
// ---------------------------------------------------------------------------
interface mem_cmd_if;
  logic [1:0]  memCmd;
  logic [63:0] memAddrOut;
  logic [31:0] ioDataOut;
  logic        ioCmdDoneOut;
  logic        memCmdDoneIn;
  logic [31:0] memDataIn;
  logic        addrErr;
`ifdef PARITY_CHECK_EN
  logic        parErr;
`endif

  modport master (
    output memCmd, memAddrOut, ioDataOut, ioCmdDoneOut,
`ifdef PARITY_CHECK_EN
    input  parErr,
`endif
    input  memCmdDoneIn, memDataIn, addrErr
  );

  modport slave (
    input  memCmd, memAddrOut, ioDataOut, ioCmdDoneOut,
`ifdef PARITY_CHECK_EN
    output parErr,
`endif
    output memCmdDoneIn, memDataIn, addrErr
  );
endinterface

// File: rtl/mem_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// mem_cmd_ctrl
// Memory command stage behind the I/O control block. Executes WRITE, READ and
// CLEAR against an internal 2**ADDR_W x 32-bit word store and reports
// completion, read data and address errors back upstream.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset (does not clear the word store)
//   bus    mem_cmd_if.slave (command, address, data, handshake, results)
//
// Parameters:
//   ADDR_W    implemented address bits (store depth = 2**ADDR_W)
//   READ_LAT  clock edges from read start to data valid (1..4)
//
// Optional feature macro: PARITY_CHECK_EN stores an even-parity bit per word
// and pulses bus.parErr on a READ whose stored parity does not match.
// ---------------------------------------------------------------------------
module mem_cmd_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_cmd_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARITY_CHECK_EN
  localparam int WORD_W = 33;  // {parity, data}
`else
  localparam int WORD_W = 32;
`endif

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [1:0]        LAT_LAST = 2'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  logic [2:0]        state;
  logic              req_q;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        lat_cnt;
  logic              done;
  logic [31:0]       data_out;
  logic              addr_err;

  logic              req;
  logic              out_of_range;

  assign req          = bus.ioCmdDoneOut & ~req_q;
  assign out_of_range = |bus.memAddrOut[63:ADDR_W];

  // ---------------------------------------------------------------- store
  logic [WORD_W-1:0] store [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_word;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_q;
    wr_word = '0;
    case (state)
      S_WRITE: begin
        wr_en = 1'b1;
`ifdef PARITY_CHECK_EN
        wr_word = {^data_q, data_q};  // even parity over the data word
`else
        wr_word = data_q;
`endif
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt;                // CLEAR zeroes data and parity
      end
      default: ;
    endcase
  end

  // NOTE: the word array has no reset; only CLEAR zeroes it, so a reset in
  // the middle of a CLEAR leaves the not-yet-visited words intact.
  always_ff @(posedge clk) begin
    if (wr_en) store[wr_addr] <= wr_word;
  end

  // ------------------------------------------------------------ read path
  // The registered read is the final capture into data_out; READ_LAT-1
  // extra stages sit in front of it. addr_q is stable for the whole READ.
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] rd_tail;

  assign rd_word = store[addr_q];

  generate
    if (READ_LAT > 1) begin : g_pipe
      logic [WORD_W-1:0] pipe [READ_LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < READ_LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= rd_word;
          for (int i = 1; i < READ_LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign rd_tail = pipe[READ_LAT-2];
    end else begin : g_direct
      assign rd_tail = rd_word;
    end
  endgenerate

  // ------------------------------------------------------------------ FSM
`ifdef PARITY_CHECK_EN
  logic par_err;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      addr_q   <= '0;
      data_q   <= '0;
      cnt      <= '0;
      lat_cnt  <= '0;
      done     <= 1'b1;
      data_out <= '0;
      addr_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err  <= 1'b0;
`endif
    end else begin
      req_q    <= bus.ioCmdDoneOut;
      addr_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req && bus.memCmd != CMD_NOP) begin
            cmd_q   <= bus.memCmd;
            addr_q  <= bus.memAddrOut[ADDR_W-1:0];
            data_q  <= bus.ioDataOut;
            cnt     <= '0;
            lat_cnt <= '0;
            done    <= 1'b0;
            if (bus.memCmd == CMD_CLEAR)      state <= S_CLEAR;
            else if (out_of_range)            state <= S_ERR;
            else if (bus.memCmd == CMD_WRITE) state <= S_WRITE;
            else                              state <= S_READ;
          end
        end
        S_WRITE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_READ: begin
          if (lat_cnt == LAT_LAST) begin
            data_out <= rd_tail[31:0];
`ifdef PARITY_CHECK_EN
            par_err  <= ^rd_tail;     // nonzero XOR of data+parity = mismatch
`endif
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == CNT_LAST) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ERR: begin
          addr_err <= 1'b1;
          done     <= 1'b1;
          if (cmd_q == CMD_READ) data_out <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.memCmdDoneIn = done;
  assign bus.memDataIn    = data_out;
  assign bus.addrErr      = addr_err;
`ifdef PARITY_CHECK_EN
  assign bus.parErr       = par_err;
`endif

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_cmd_ctrl
// Directed self-checking bench for mem_cmd_ctrl (ADDR_W=8, READ_LAT=1).
// Expected read data comes from a bench-side word model and is queued when a
// READ is issued, then popped when the controller reports completion.
// ---------------------------------------------------------------------------
module tb_mem_cmd_ctrl;
  localparam int ADDR_W   = 8;
  localparam int READ_LAT = 1;
  localparam int DEPTH    = 2 ** ADDR_W;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_cmd_if bus();

  mem_cmd_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          par_hits    = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and count the cycles memCmdDoneIn stays low after the
  // accepting edge; errs counts addrErr over the completion cycle and the
  // one after it (a clean one-cycle pulse gives 1).
  task automatic issue(input logic [1:0] cmd, input logic [63:0] addr,
                       input logic [31:0] data, input int budget,
                       output int low, output int errs);
    @(negedge clk);
    bus.memCmd       = cmd;
    bus.memAddrOut   = addr;
    bus.ioDataOut    = data;
    bus.ioCmdDoneOut = 1'b1;
    low = 0;
    @(negedge clk);
    bus.ioCmdDoneOut = 1'b0;
    while (bus.memCmdDoneIn == 1'b0 && low < budget) begin
      low++;
      @(negedge clk);
    end
    errs = int'(bus.addrErr);
`ifdef PARITY_CHECK_EN
    par_hits += int'(bus.parErr);
`endif
    @(negedge clk);
    errs += int'(bus.addrErr);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [31:0] data,
                          input bit exp_err, input string tag);
    int low, errs;
    issue(CMD_WRITE, addr, data, 16, low, errs);
    check({tag, " low"}, 64'(low), 64'(1));
    check({tag, " err"}, 64'(errs), 64'(exp_err));
    if (!exp_err) model[addr[ADDR_W-1:0]] = data;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [31:0] exp,
                         input bit exp_err, input string tag);
    int low, errs;
    exp_q.push_back(exp);
    issue(CMD_READ, addr, 32'h0, 16, low, errs);
    check({tag, " low"},  64'(low), exp_err ? 64'(1) : 64'(READ_LAT));
    check({tag, " err"},  64'(errs), 64'(exp_err));
    check({tag, " data"}, 64'(bus.memDataIn), 64'(exp_q.pop_front()));
    check({tag, " done"}, 64'(bus.memCmdDoneIn), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low, errs;
    bus.memCmd       = CMD_NOP;
    bus.memAddrOut   = '0;
    bus.ioDataOut    = '0;
    bus.ioCmdDoneOut = 1'b0;

    // Reset held, then released with no activity.
    repeat (3) @(negedge clk);
    check("rst done", 64'(bus.memCmdDoneIn), 64'(1));
    check("rst data", 64'(bus.memDataIn),    64'(0));
    check("rst err",  64'(bus.addrErr),      64'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle done", 64'(bus.memCmdDoneIn), 64'(1));
    check("idle data", 64'(bus.memDataIn),    64'(0));
    check("idle err",  64'(bus.addrErr),      64'(0));

    // Basic write/read.
    do_write(64'h0F, 32'hDEADBEEF, 1'b0, "wr 0f");
    do_read (64'h0F, model[8'h0F], 1'b0, "rd 0f");

    // Fill both ends, then CLEAR with a WRITE request poked mid-clear.
    do_write(64'h00, 32'h12345678, 1'b0, "wr 00");
    do_write(64'hFF, 32'h12345678, 1'b0, "wr ff");
    do_read (64'hFF, model[8'hFF], 1'b0, "rd ff pre");
    @(negedge clk);
    bus.memCmd       = CMD_CLEAR;
    bus.ioCmdDoneOut = 1'b1;
    @(negedge clk);
    bus.ioCmdDoneOut = 1'b0;
    low = 0;
    while (bus.memCmdDoneIn == 1'b0 && low < 400) begin
      if (low == 120) begin
        bus.memCmd       = CMD_WRITE;
        bus.memAddrOut   = 64'h33;
        bus.ioDataOut    = 32'h11111111;
        bus.ioCmdDoneOut = 1'b1;
      end
      if (low == 122) bus.ioCmdDoneOut = 1'b0;
      low++;
      @(negedge clk);
    end
    check("clear low", 64'(low), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("clear idle done", 64'(bus.memCmdDoneIn), 64'(1));
    do_read(64'h00, model[8'h00], 1'b0, "rd 00 clr");
    do_read(64'hFF, model[8'hFF], 1'b0, "rd ff clr");
    do_read(64'h33, model[8'h33], 1'b0, "rd 33 drop");

    // Out-of-range READ clears memDataIn; out-of-range WRITE is discarded.
    do_write(64'hC8, 32'hA5A5A5A5, 1'b0, "wr c8");
    do_read (64'hC8, model[8'hC8], 1'b0, "rd c8");
    do_read (64'h100, 32'h0, 1'b1, "rd oor");
    do_write(64'h1_0000_0000, 32'hFFFFFFFF, 1'b1, "wr oor");
    do_read (64'h00, model[8'h00], 1'b0, "rd 00 after oor");

    // NOP request never drops done.
    issue(CMD_NOP, 64'h0F, 32'h0, 8, low, errs);
    check("nop low", 64'(low), 64'(0));
    check("nop err", 64'(errs), 64'(0));
    repeat (3) @(negedge clk);
    check("nop done", 64'(bus.memCmdDoneIn), 64'(1));

    // Reset after 100 words of a CLEAR have been zeroed.
    do_write(64'h50, 32'h5555AAAA, 1'b0, "wr 50");
    do_read (64'hC8, model[8'hC8], 1'b0, "rd c8 pre");
    @(negedge clk);
    bus.memCmd       = CMD_CLEAR;
    bus.ioCmdDoneOut = 1'b1;
    @(negedge clk);
    bus.ioCmdDoneOut = 1'b0;
    repeat (100) @(negedge clk);
    check("midclr busy", 64'(bus.memCmdDoneIn), 64'(0));
    rst_n = 1'b0;
    #1;
    check("midclr rst done", 64'(bus.memCmdDoneIn), 64'(1));
    check("midclr rst data", 64'(bus.memDataIn),    64'(0));
    for (int i = 0; i < 100; i++) model[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(64'h50, model[8'h50], 1'b0, "rd 50 partial");
    do_read(64'hC8, model[8'hC8], 1'b0, "rd c8 kept");

`ifdef PARITY_CHECK_EN
    check("parity pulses", 64'(par_hits), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
